// File: rtl/qick_mem_pkg.sv
// Shared types and elaboration helpers for the register-file stack/queue buffers.
package qick_mem_pkg;

    typedef enum logic {STACK_LIFO, STACK_FIFO} stack_mode_t;

    function automatic stack_mode_t mode_from_str(input logic [31:0] s);
        return (s == "FIFO") ? STACK_FIFO : STACK_LIFO;
    endfunction

    function automatic logic mode_valid(input logic [31:0] s);
        return (s == "LIFO") || (s == "FIFO");
    endfunction

    // Index width for a DEPTH-entry array; never narrower than one bit.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mod_ptr.sv
// Modulo-DEPTH pointer with explicit wrap, so DEPTH need not be a power of two.
module mod_ptr
    import qick_mem_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PW    = ptr_w(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clr_i,
    input  logic          inc_i,
    output logic [PW-1:0] ptr_o,
    output logic          wrap_o
);

    assign wrap_o = inc_i && (ptr_o == PW'(DEPTH - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_o <= '0;
        end else if (clr_i) begin
            ptr_o <= '0;
        end else if (inc_i) begin
            ptr_o <= wrap_o ? '0 : ptr_o + PW'(1);
        end
    end

endmodule

// File: rtl/sync_stack_queue.sv
// Single-clock register-file buffer, LIFO or FIFO ordering, with occupancy
// count, sticky overflow/underflow flags and a synchronous flush.
module sync_stack_queue
    import qick_mem_pkg::*;
#(
    parameter int          WIDTH = 16,
    parameter int          DEPTH = 8,
    parameter logic [31:0] MODE  = "LIFO"
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clear_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           data_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       ovf_o,
    output logic                       unf_o
);

    localparam int          CW     = $clog2(DEPTH + 1);
    localparam int          PW     = ptr_w(DEPTH);
    localparam stack_mode_t MODE_E = mode_from_str(MODE);

    logic [CW-1:0] count_q;
    logic          empty, full;
    logic          push_acc, pop_acc;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));

    // Push+pop on a non-empty buffer is always legal, even when full.
    assign push_acc = !clear_i && push_i && (!full || (pop_i && !empty));
    assign pop_acc  = !clear_i && pop_i && !empty;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
            ovf_o   <= 1'b0;
            unf_o   <= 1'b0;
        end else if (clear_i) begin
            count_q <= '0;
            ovf_o   <= 1'b0;
            unf_o   <= 1'b0;
        end else begin
            count_q <= count_q + CW'(push_acc) - CW'(pop_acc);
            ovf_o   <= ovf_o | (push_i && !pop_i && full);
            unf_o   <= unf_o | (pop_i && empty);
        end
    end

    assign empty_o = empty;
    assign full_o  = full;
    assign count_o = count_q;

    if (!mode_valid(MODE)) begin : g_bad_mode
        $error("sync_stack_queue: MODE must be \"LIFO\" or \"FIFO\"");
        assign data_o = '0;
    end else if (MODE_E == STACK_LIFO) begin : g_lifo
        logic [WIDTH-1:0] stack_q [DEPTH];
        logic [PW-1:0]    top_idx, wr_idx;

        // The stack pointer equals the occupancy count.
        assign top_idx = PW'(count_q - CW'(1));
        assign wr_idx  = pop_acc ? top_idx : PW'(count_q);

        always_ff @(posedge clk_i) begin
            if (push_acc) begin
                stack_q[wr_idx] <= data_i;
            end
        end

        assign data_o = empty ? '0 : stack_q[top_idx];
    end else begin : g_fifo
        logic [WIDTH-1:0] mem_q [DEPTH];
        logic [PW-1:0]    wr_ptr, rd_ptr;
        logic             wr_wrap_unused, rd_wrap_unused;

        mod_ptr #(.DEPTH(DEPTH), .PW(PW)) u_wr_ptr (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .clr_i  (clear_i),
            .inc_i  (push_acc),
            .ptr_o  (wr_ptr),
            .wrap_o (wr_wrap_unused)
        );

        mod_ptr #(.DEPTH(DEPTH), .PW(PW)) u_rd_ptr (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .clr_i  (clear_i),
            .inc_i  (pop_acc),
            .ptr_o  (rd_ptr),
            .wrap_o (rd_wrap_unused)
        );

        always_ff @(posedge clk_i) begin
            if (push_acc) begin
                mem_q[wr_ptr] <= data_i;
            end
        end

        assign data_o = empty ? '0 : mem_q[rd_ptr];
    end

endmodule

// File: tb/tb_sync_stack_queue.sv
// Directed bench for sync_stack_queue: one LIFO and one FIFO instance, DEPTH=5.
module tb_sync_stack_queue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        l_clear = 0, l_push = 0, l_pop = 0;
    logic [15:0] l_din = '0, l_dout;
    logic        l_empty, l_full, l_ovf, l_unf;
    logic [2:0]  l_count;

    logic        f_clear = 0, f_push = 0, f_pop = 0;
    logic [15:0] f_din = '0, f_dout;
    logic        f_empty, f_full, f_ovf, f_unf;
    logic [2:0]  f_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sync_stack_queue #(.WIDTH(16), .DEPTH(5), .MODE("LIFO")) u_lifo (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(l_clear), .push_i(l_push), .pop_i(l_pop),
        .data_i(l_din), .data_o(l_dout), .empty_o(l_empty), .full_o(l_full),
        .count_o(l_count), .ovf_o(l_ovf), .unf_o(l_unf)
    );

    sync_stack_queue #(.WIDTH(16), .DEPTH(5), .MODE("FIFO")) u_fifo (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(f_clear), .push_i(f_push), .pop_i(f_pop),
        .data_i(f_din), .data_o(f_dout), .empty_o(f_empty), .full_o(f_full),
        .count_o(f_count), .ovf_o(f_ovf), .unf_o(f_unf)
    );

    // Status vector: {count, empty, full, ovf, unf, data} = 23 bits.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if ({l_count, l_empty, l_full, l_ovf, l_unf, l_dout} !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0}) begin
            n_bad++;
            $display("FAIL reset_lifo: got %h want %h", {l_count, l_empty, l_full, l_ovf, l_unf, l_dout}, {3'd0, 4'b1000, 16'h0});
        end
        n_cmp++;
        if ({f_count, f_empty, f_full, f_ovf, f_unf, f_dout} !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0}) begin
            n_bad++;
            $display("FAIL reset_fifo: got %h want %h", {f_count, f_empty, f_full, f_ovf, f_unf, f_dout}, {3'd0, 4'b1000, 16'h0});
        end
        tick();
        tick();
        rst_n = 1'b1;
        l_push = 1; f_push = 1;
        for (int i = 1; i <= 3; i++) begin
            l_din = 16'(i * 16'h11); f_din = 16'(i * 16'h11);
            tick();
        end
        n_cmp++;
        if ({l_count, l_dout} !== {3'd3, 16'h0033}) begin
            n_bad++;
            $display("FAIL burst_lifo: got %h want %h", {l_count, l_dout}, {3'd3, 16'h0033});
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({l_count, l_empty, l_full, l_ovf, l_unf, l_dout} !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0}) begin
            n_bad++;
            $display("FAIL midreset_lifo: got %h want %h", {l_count, l_empty, l_full, l_ovf, l_unf, l_dout}, {3'd0, 4'b1000, 16'h0});
        end
        n_cmp++;
        if ({f_count, f_empty, f_full, f_ovf, f_unf, f_dout} !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0}) begin
            n_bad++;
            $display("FAIL midreset_fifo: got %h want %h", {f_count, f_empty, f_full, f_ovf, f_unf, f_dout}, {3'd0, 4'b1000, 16'h0});
        end
        l_push = 0; f_push = 0;
        rst_n = 1'b1;
        tick();
        l_pop = 1; f_pop = 1;
        tick();
        l_pop = 0; f_pop = 0;
        n_cmp++;
        if ({l_count, l_empty, l_unf, l_dout} !== {3'd0, 1'b1, 1'b1, 16'h0}) begin
            n_bad++;
            $display("FAIL unf_lifo: got %h want %h", {l_count, l_empty, l_unf, l_dout}, {3'd0, 2'b11, 16'h0});
        end
        n_cmp++;
        if ({f_count, f_empty, f_unf, f_dout} !== {3'd0, 1'b1, 1'b1, 16'h0}) begin
            n_bad++;
            $display("FAIL unf_fifo: got %h want %h", {f_count, f_empty, f_unf, f_dout}, {3'd0, 2'b11, 16'h0});
        end
    endtask

    task automatic test_lifo_fill();
        l_clear = 1; tick(); l_clear = 0;
        n_cmp++;
        if ({l_unf, l_ovf, l_count} !== {1'b0, 1'b0, 3'd0}) begin
            n_bad++;
            $display("FAIL lifo_clear_flags: got %h want %h", {l_unf, l_ovf, l_count}, 5'h0);
        end
        l_push = 1;
        for (int i = 1; i <= 5; i++) begin
            l_din = 16'(i);
            tick();
            n_cmp++;
            if ({l_count, l_empty, l_full, l_dout} !== {3'(i), 1'b0, (i == 5), 16'(i)}) begin
                n_bad++;
                $display("FAIL lifo_fill_%0d: got %h want %h", i, {l_count, l_empty, l_full, l_dout}, {3'(i), 1'b0, (i == 5), 16'(i)});
            end
        end
        l_din = 16'hDEAD;
        tick();
        l_push = 0;
        n_cmp++;
        if ({l_count, l_full, l_ovf, l_dout} !== {3'd5, 1'b1, 1'b1, 16'h0005}) begin
            n_bad++;
            $display("FAIL lifo_ovf: got %h want %h", {l_count, l_full, l_ovf, l_dout}, {3'd5, 2'b11, 16'h0005});
        end
        l_pop = 1;
        for (int i = 4; i >= 0; i--) begin
            tick();
            n_cmp++;
            if ({l_count, l_empty, l_full, l_dout} !== {3'(i), (i == 0), 1'b0, 16'(i)}) begin
                n_bad++;
                $display("FAIL lifo_drain_%0d: got %h want %h", i, {l_count, l_empty, l_full, l_dout}, {3'(i), (i == 0), 1'b0, 16'(i)});
            end
        end
        l_pop = 0;
        n_cmp++;
        if ({l_ovf, l_unf} !== 2'b10) begin
            n_bad++;
            $display("FAIL lifo_sticky: got %b want 10", {l_ovf, l_unf});
        end
    endtask

    task automatic test_lifo_push_pop();
        l_clear = 1; tick(); l_clear = 0;
        l_push = 1; l_din = 16'h0001; tick();
        l_din = 16'h0002; tick();
        l_pop = 1; l_din = 16'hBEEF; tick();
        l_push = 0; l_pop = 0;
        n_cmp++;
        if ({l_count, l_dout} !== {3'd2, 16'hBEEF}) begin
            n_bad++;
            $display("FAIL lifo_replace: got %h want %h", {l_count, l_dout}, {3'd2, 16'hBEEF});
        end
        l_pop = 1; tick(); l_pop = 0;
        n_cmp++;
        if ({l_count, l_dout} !== {3'd1, 16'h0001}) begin
            n_bad++;
            $display("FAIL lifo_after_replace: got %h want %h", {l_count, l_dout}, {3'd1, 16'h0001});
        end
    endtask

    task automatic test_fifo_wrap();
        f_clear = 1; tick(); f_clear = 0;
        f_push = 1;
        for (int i = 0; i < 3; i++) begin
            f_din = 16'(16'hA0 + i);
            tick();
        end
        n_cmp++;
        if ({f_count, f_dout} !== {3'd3, 16'h00A0}) begin
            n_bad++;
            $display("FAIL fifo_prefill: got %h want %h", {f_count, f_dout}, {3'd3, 16'h00A0});
        end
        f_pop = 1;
        for (int k = 0; k < 12; k++) begin
            f_din = 16'(16'hA3 + k);
            tick();
            n_cmp++;
            if ({f_count, f_dout} !== {3'd3, 16'(16'hA1 + k)}) begin
                n_bad++;
                $display("FAIL fifo_wrap_%0d: got %h want %h", k, {f_count, f_dout}, {3'd3, 16'(16'hA1 + k)});
            end
        end
        f_push = 0; f_pop = 0;
    endtask

    task automatic test_fifo_empty_push_pop();
        f_clear = 1; tick(); f_clear = 0;
        f_push = 1; f_pop = 1; f_din = 16'h1234; tick();
        f_push = 0; f_pop = 0;
        n_cmp++;
        if ({f_count, f_empty, f_unf, f_dout} !== {3'd1, 1'b0, 1'b1, 16'h1234}) begin
            n_bad++;
            $display("FAIL fifo_empty_pp: got %h want %h", {f_count, f_empty, f_unf, f_dout}, {3'd1, 2'b01, 16'h1234});
        end
    endtask

    task automatic test_clear_priority();
        f_clear = 1; l_clear = 1; tick(); f_clear = 0; l_clear = 0;
        f_push = 1; l_push = 1;
        for (int i = 0; i < 5; i++) begin
            f_din = 16'(16'h10 + i); l_din = 16'(16'h10 + i);
            tick();
        end
        f_pop = 1; f_din = 16'h0015; l_din = 16'h0015;
        tick();
        f_pop = 0;
        n_cmp++;
        if ({f_count, f_full, f_ovf, f_unf, f_dout} !== {3'd5, 1'b1, 1'b0, 1'b0, 16'h0011}) begin
            n_bad++;
            $display("FAIL fifo_full_pp: got %h want %h", {f_count, f_full, f_ovf, f_unf, f_dout}, {3'd5, 3'b100, 16'h0011});
        end
        n_cmp++;
        if ({l_count, l_ovf, l_dout} !== {3'd5, 1'b1, 16'h0014}) begin
            n_bad++;
            $display("FAIL lifo_full_ovf: got %h want %h", {l_count, l_ovf, l_dout}, {3'd5, 1'b1, 16'h0014});
        end
        f_din = 16'h0016; tick();
        n_cmp++;
        if ({f_count, f_ovf, f_dout} !== {3'd5, 1'b1, 16'h0011}) begin
            n_bad++;
            $display("FAIL fifo_ovf: got %h want %h", {f_count, f_ovf, f_dout}, {3'd5, 1'b1, 16'h0011});
        end
        f_clear = 1; l_clear = 1; f_din = 16'h0099; l_din = 16'h0099;
        tick();
        f_clear = 0; l_clear = 0; f_push = 0; l_push = 0;
        n_cmp++;
        if ({f_count, f_empty, f_full, f_ovf, f_unf, f_dout} !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0}) begin
            n_bad++;
            $display("FAIL fifo_clear: got %h want %h", {f_count, f_empty, f_full, f_ovf, f_unf, f_dout}, {3'd0, 4'b1000, 16'h0});
        end
        n_cmp++;
        if ({l_count, l_empty, l_full, l_ovf, l_unf, l_dout} !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0}) begin
            n_bad++;
            $display("FAIL lifo_clear: got %h want %h", {l_count, l_empty, l_full, l_ovf, l_unf, l_dout}, {3'd0, 4'b1000, 16'h0});
        end
    endtask

    initial begin
        test_reset();
        test_lifo_fill();
        test_lifo_push_pop();
        test_fifo_wrap();
        test_fifo_empty_push_pop();
        test_clear_priority();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sync_stack_queue.md
# sync_stack_queue

Single-clock register-file buffer, parametrised in width, depth and ordering mode: LIFO (return/loop stack) or FIFO (command queue). It generalises the processor's fixed-depth stack. It adds:
- arbitrary non-power-of-two depth
- simultaneous push/pop
- an occupancy count
- sticky overflow/underflow flags
- a synchronous flush

It sits inside the processor core, between the control FSM and the instruction/register datapath.

## Interface
Parameters:
- `WIDTH`, 16, data word width in bits (1..256).
- `DEPTH`, 8, number of entries (2..1024; need not be a power of two).
- `MODE`, "LIFO", ordering; "LIFO" or "FIFO". Any other value is an elaboration error.

Ports:
- `clk_i`  in  1  clock; all state on rising edge.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `clear_i`  in  1  synchronous flush; empties the buffer and clears error flags.
- `push_i`  in  1  write `data_i` this cycle.
- `pop_i`  in  1  remove the current output word this cycle.
- `data_i`  in  WIDTH  write data.
- `data_o`  out  WIDTH  top (LIFO) or head (FIFO) entry; zero when empty.
- `empty_o`  out  1  count == 0.
- `full_o`  out  1  count == DEPTH.
- `count_o`  out  $clog2(DEPTH+1)  number of valid entries.
- `ovf_o`  out  1  sticky; a push was rejected.
- `unf_o`  out  1  sticky; a pop was rejected.

## Operation
- Storage is a DEPTH x WIDTH register array. Its content is not reset; only pointers, count and flags are.
- LIFO uses one pointer `ptr` (0..DEPTH). Write goes to `stack[ptr]`; `data_o` = `stack[ptr-1]`.
- FIFO uses `wr_ptr`, `rd_ptr` (0..DEPTH-1) plus `count`. Pointers wrap from DEPTH-1 to 0 explicitly, with no power-of-two masking. `data_o` = `mem[rd_ptr]`.
- Event resolution per cycle, in priority order:
  1. `clear_i`: count and pointers go to 0; `ovf_o`, `unf_o` go to 0; push/pop that cycle are ignored.
  2. push & pop, not empty:
     - LIFO: top entry replaced by `data_i`; ptr unchanged.
     - FIFO: write at `wr_ptr`, advance both pointers; count unchanged. This holds also when full.
  3. push & pop, empty: push accepted, pop rejected, `unf_o` set.
  4. push only: accepted if not full. If full, rejected: storage and count unchanged, `ovf_o` set.
  5. pop only: accepted if not empty. If empty, rejected: `unf_o` set.
- `ovf_o`/`unf_o` stay high until `clear_i` or reset.
- `data_o` is forced to zero while empty, so stale storage is never visible.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert by the system) gives:
  - `empty_o`=1, `full_o`=0, `count_o`=0, `ovf_o`=0, `unf_o`=0, `data_o`=0.
- Write-to-read latency is 1 cycle. A push sampled on edge n appears on `data_o`, `count_o`, `empty_o`, `full_o` after edge n; no bypass within the same cycle.
- `data_o` is combinational from the registered pointer and storage only. It has no path from `push_i`, `pop_i` or `data_i`.
- Flags assert on the edge that samples the rejected request.
- `clear_i` takes effect on the sampling edge: the outputs show the empty state in the next cycle.
- Reset asserted mid-operation discards all content immediately, independent of the clock.
- Throughput is one push and/or one pop per cycle, sustained, with no bubbles at wrap-around (FIFO pointer DEPTH-1 → 0).

## Structure
- Shared package `qick_mem_pkg` holds:
  - `typedef enum {STACK_LIFO, STACK_FIFO} stack_mode_t` and the string-to-enum function.
  - A `ptr_w(DEPTH)` helper constant function.
- One sub-module: `mod_ptr`, a modulo-DEPTH pointer with inc/clr inputs and a wrap flag. It is instantiated twice in FIFO mode and unused in LIFO mode.
- MODE is selected with a generate block. Count, flags and clear logic are shared between modes.

## Test plan
- Reset/idle, WIDTH=16, DEPTH=5, both modes: assert `rst_ni`=0 mid-burst → all outputs at reset values in the same cycle; pop after release → `unf_o`=1, `count_o`=0.
- LIFO fill/drain: push 0x0001..0x0005 → `full_o`=1, `data_o`=0x0005. Sixth push of 0xDEAD → `ovf_o`=1, `data_o` still 0x0005. Five pops → `data_o` 0x0004..0x0001 then 0, `empty_o`=1.
- LIFO push+pop: with 0x0001,0x0002 stored, push+pop 0xBEEF → `data_o`=0xBEEF, `count_o`=2. Then pop → `data_o`=0x0001.
- FIFO wrap, DEPTH=5: 12 cycles of push+pop after pre-filling 3 words (0xA0..0xA2) → order preserved across two pointer wraps, `count_o` constant at 3.
- Empty push+pop, FIFO: push+pop 0x1234 on empty → `count_o`=1, `data_o`=0x1234, `unf_o`=1.
- Clear priority: `clear_i`=1 with push on a full buffer → next cycle `count_o`=0, `ovf_o`=0, `unf_o`=0, `data_o`=0.
